// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH -> DECODE -> EXEC control sequencer for the LEGv8 single-bus datapath.
// Holds the instruction register and drives every datapath control field from it.
module multicycle_sequencer #(
    parameter logic [4:0] FS_ADD = 5'b01000,
    parameter logic [4:0] FS_SUB = 5'b01011,
    parameter logic [4:0] FS_AND = 5'b00000,
    parameter logic [4:0] FS_ORR = 5'b00100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    input  logic        stall,
    output logic [63:0] constant,
    output logic        EN_PC,
    output logic        EN_Mem,
    output logic        EN_ALU,
    output logic        EN_B,
    output logic        PCsel,
    output logic        Bsel,
    output logic        SL,
    output logic        WM,
    output logic        WR,
    output logic [1:0]  PS,
    output logic [4:0]  FS,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic [1:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALT   = 2'b11
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
        OP_LDUR, OP_STUR, OP_B, OP_BL, OP_BR, OP_CBZ, OP_CBNZ
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    op_t         op;

    logic [4:0]  rd, rn, rm;
    logic [63:0] immArith, immMem, immBranch, immCond;

    // The registered flags status[4:1] have no consumer in this instruction subset.
    logic unusedStatusFlags;
    assign unusedStatusFlags = ^status[4:1];

    assign rd = ir_q[4:0];
    assign rn = ir_q[9:5];
    assign rm = ir_q[20:16];

    assign immArith  = {52'b0, ir_q[21:10]};
    assign immMem    = {{55{ir_q[20]}}, ir_q[20:12]};
    assign immBranch = {{38{ir_q[25]}}, ir_q[25:0]};
    assign immCond   = {{45{ir_q[23]}}, ir_q[23:5]};

    assign state         = state_q;
    assign illegal       = illegal_q;
    assign retired_count = count_q;

    always_comb begin
        op = OP_NONE;
        casez (ir_q[31:21])
            11'b10001011000: op = OP_ADD;
            11'b11001011000: op = OP_SUB;
            11'b11101011000: op = OP_SUBS;
            11'b10001010000: op = OP_AND;
            11'b10101010000: op = OP_ORR;
            11'b1001000100?: op = OP_ADDI;
            11'b1101000100?: op = OP_SUBI;
            11'b11111000010: op = OP_LDUR;
            11'b11111000000: op = OP_STUR;
            11'b000101?????: op = OP_B;
            11'b100101?????: op = OP_BL;
            11'b11010110000: op = OP_BR;
            11'b10110100???: op = OP_CBZ;
            11'b10110101???: op = OP_CBNZ;
            default:         op = OP_NONE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Stall freezes everything and masks all controls, so EXEC re-issues in full afterwards.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        count_d    = count_q;
        illegal_d  = illegal_q;
        constant   = '0;
        EN_PC      = 1'b0;
        EN_Mem     = 1'b0;
        EN_ALU     = 1'b0;
        EN_B       = 1'b0;
        PCsel      = 1'b0;
        Bsel       = 1'b0;
        SL         = 1'b0;
        WM         = 1'b0;
        WR         = 1'b0;
        PS         = 2'b00;
        FS         = 5'b00000;
        SA         = 5'd0;
        SB         = 5'd0;
        DA         = 5'd0;
        instr_done = 1'b0;

        if (!stall) begin
            case (state_q)
                FETCH: begin
                    ir_d    = instruction;
                    state_d = DECODE;
                end
                DECODE: begin
                    if (op == OP_NONE) begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    state_d    = FETCH;
                    instr_done = 1'b1;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                    case (op)
                        OP_ADD, OP_SUB, OP_SUBS, OP_AND, OP_ORR: begin
                            SA     = rn;
                            SB     = rm;
                            DA     = rd;
                            EN_ALU = 1'b1;
                            WR     = 1'b1;
                            PS     = 2'b01;
                            SL     = (op == OP_SUBS);
                            case (op)
                                OP_AND:  FS = FS_AND;
                                OP_ORR:  FS = FS_ORR;
                                OP_ADD:  FS = FS_ADD;
                                default: FS = FS_SUB;
                            endcase
                        end
                        OP_ADDI, OP_SUBI: begin
                            SA       = rn;
                            DA       = rd;
                            Bsel     = 1'b1;
                            constant = immArith;
                            FS       = (op == OP_ADDI) ? FS_ADD : FS_SUB;
                            EN_ALU   = 1'b1;
                            WR       = 1'b1;
                            PS       = 2'b01;
                        end
                        OP_LDUR: begin
                            SA       = rn;
                            DA       = rd;
                            Bsel     = 1'b1;
                            constant = immMem;
                            FS       = FS_ADD;
                            EN_Mem   = 1'b1;
                            WR       = 1'b1;
                            PS       = 2'b01;
                        end
                        OP_STUR: begin
                            SA       = rn;
                            SB       = rd;
                            Bsel     = 1'b1;
                            constant = immMem;
                            FS       = FS_ADD;
                            EN_B     = 1'b1;
                            WM       = 1'b1;
                            PS       = 2'b01;
                        end
                        OP_B, OP_BL: begin
                            PCsel    = 1'b1;
                            constant = immBranch;
                            PS       = 2'b11;
                            if (op == OP_BL) begin
                                EN_PC = 1'b1;
                                WR    = 1'b1;
                                DA    = 5'd30;
                            end
                        end
                        OP_BR: begin
                            SA = rn;
                            PS = 2'b10;
                        end
                        OP_CBZ, OP_CBNZ: begin
                            // status[0] is the live zero flag of XZR + Rt computed this cycle.
                            SA       = 5'd31;
                            SB       = rd;
                            FS       = FS_ADD;
                            PCsel    = 1'b1;
                            constant = immCond;
                            PS       = ((op == OP_CBZ) == status[0]) ? 2'b11 : 2'b01;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule
